sccb_request_arbiter: RTL

//   Shares one SCCB_interface master between two register-write requesters: port 0
//   (boot-time OV7670_config engine) and port 1 (runtime tuning logic, e.g. exposure/gain).

---
 rtl/sccb_request_arbiter_if.sv | 33 +++
 rtl/sccb_request_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sccb_request_arbiter_if.sv
// Requester-side and SCCB-master-side signals of the two-port SCCB write arbiter.
// The master modport is the arbiter's view; slave is the view of its surroundings.
interface sccb_request_arbiter_if;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          req0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] data0;
  logic          ack0;
  logic          req1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] data1;
  logic          ack1;
  logic          sccb_ready;
  logic          sccb_start;
  logic [AW-1:0] sccb_addr;
  logic [DW-1:0] sccb_data;
  logic          busy;
  logic          grant;
  logic          err_flag;
  logic          err_sticky;

  modport master (
    input  req0, addr0, data0, req1, addr1, data1, sccb_ready,
    output ack0, ack1, sccb_start, sccb_addr, sccb_data, busy, grant, err_flag, err_sticky
  );

  modport slave (
    output req0, addr0, data0, req1, addr1, data1, sccb_ready,
    input  ack0, ack1, sccb_start, sccb_addr, sccb_data, busy, grant, err_flag, err_sticky
  );
endinterface

// File: rtl/sccb_request_arbiter.sv
// Round-robin arbiter sharing one SCCB master between the config engine (port 0) and
// runtime tuning (port 1), with a post-write idle gap and a long gap after COM7 reset.
module sccb_request_arbiter #(
  parameter int unsigned CLK_FREQ     = 25000000,
  parameter int unsigned GAP_US       = 10,
  parameter int unsigned RESET_GAP_MS = 1,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  sccb_request_arbiter_if.master        bus
);

  localparam int unsigned GAP_CYC = CLK_FREQ / 1000000 * GAP_US;
  localparam int unsigned RST_CYC = CLK_FREQ / 1000 * RESET_GAP_MS;
  localparam int unsigned GAP_MAX = (RST_CYC > GAP_CYC) ? RST_CYC : GAP_CYC;
  localparam int unsigned GW      = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;
  localparam int unsigned TW      = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0;
  localparam logic [7:0]  COM7    = 8'h12;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK, GAP} state_t;

  state_t        state, next_state;
  logic          last_grant;
  logic          grant_q;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic          start_q;
  logic          ack0_q;
  logic          ack1_q;
  logic          busy_q;
  logic          err_flag_q;
  logic          err_sticky_q;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;

  logic          do_grant_c;
  logic          win_c;
  logic          timeout_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and arbitration decision
  always_comb begin
    next_state = state;
    do_grant_c = 1'b0;
    win_c      = 1'b0;
    timeout_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sccb_ready && (bus.req0 || bus.req1)) begin
          do_grant_c = 1'b1;
          // On a tie the port that did not own the last write wins
          win_c      = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
          next_state = ISSUE;
        end
      end
      ISSUE:     next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!bus.sccb_ready) begin
          next_state = WAIT_DONE;
        end else if (tcnt >= TW'(TO_LAST)) begin
          timeout_c  = 1'b1;
          next_state = ACK;
        end
      end
      WAIT_DONE: if (bus.sccb_ready) next_state = ACK;
      ACK:       next_state = GAP;
      GAP:       if (gcnt == '0) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Registered outputs, latched transaction and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant   <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      start_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_flag_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      tcnt         <= '0;
      gcnt         <= '0;
    end else begin
      start_q <= (next_state == ISSUE);
      busy_q  <= (next_state != IDLE);
      ack0_q  <= (next_state == ACK) && !grant_q;
      ack1_q  <= (next_state == ACK) &&  grant_q;

      if (do_grant_c) begin
        grant_q    <= win_c;
        addr_q     <= win_c ? bus.addr1 : bus.addr0;
        data_q     <= win_c ? bus.data1 : bus.data0;
        err_flag_q <= 1'b0;
      end

      if (timeout_c) begin
        err_flag_q   <= 1'b1;
        err_sticky_q <= 1'b1;
      end

      if (state == ISSUE)          tcnt <= '0;
      else if (state == WAIT_BUSY) tcnt <= tcnt + TW'(1);

      // A COM7 soft reset needs the sensor to settle far longer than a normal write
      if (state == ACK) begin
        last_grant <= grant_q;
        gcnt       <= (addr_q == COM7 && data_q[7]) ? GW'(RST_CYC) : GW'(GAP_CYC);
      end else if (state == GAP && gcnt != '0) begin
        gcnt <= gcnt - GW'(1);
      end
    end
  end

  assign bus.sccb_start = start_q;
  assign bus.sccb_addr  = addr_q;
  assign bus.sccb_data  = data_q;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.busy       = busy_q;
  assign bus.grant      = grant_q;
  assign bus.err_flag   = err_flag_q;
  assign bus.err_sticky = err_sticky_q;

endmodule
